slc3_stim_seq: RTL and testbench

SLC3_STIM_SEQ -- requirements
Module: slc3_stim_seq

---
 rtl/slc3_stim_pkg.sv | 41 ++++
 rtl/slc3_stim_seq_ram.sv | 23 ++
 rtl/slc3_stim_seq.sv | 179 +++++++++++++++++
 tb/tb_slc3_stim_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_stim_pkg.sv
// Shared types for the SLC-3 stimulus sequencer: script ops, FSM states, entry layout.
// Optional macro STIM_SEQ_HANDSHAKE_EN adds the WAIT_RDY state.
package slc3_stim_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_RUN  = 2'd1,
    OP_CONT = 2'd2,
    OP_END  = 2'd3
  } op_e;

`ifdef STIM_SEQ_HANDSHAKE_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DELAY,
    ST_PULSE,
    ST_WAIT_RDY,
    ST_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DELAY,
    ST_PULSE,
    ST_DONE
  } state_e;
`endif

  // Entry layout at the default widths; the top slices by its own parameters.
  localparam int SW_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    op_e                  op;
    logic [SW_W_DEF-1:0]  sw;
    logic [CNT_W_DEF-1:0] delay;
  } entry_t;

endpackage

// File: rtl/slc3_stim_seq_ram.sv
// Script storage: DEPTH x W, one synchronous write port, one async read port.
// Ports: clk_i, we_i/waddr_i/wdata_i write, raddr_i -> rdata_o read. Contents not reset.
module stim_script_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 34
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slc3_stim_seq.sv
// Scripted Run/Continue/SW stimulus sequencer for the SLC-3 CPU.
// Ports: Clk, Reset (sync high), script write (wr_en/wr_addr/wr_data), start, abort,
// ready; outputs SW, Run, Continue, busy, done, step_idx. Macro: STIM_SEQ_HANDSHAKE_EN.
module slc3_stim_seq
  import slc3_stim_pkg::*;
#(
  parameter int SW_W    = 16,
  parameter int DEPTH   = 32,
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [2+SW_W+CNT_W-1:0]   wr_data,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      ready,
  output logic [SW_W-1:0]           SW,
  output logic                      Run,
  output logic                      Continue,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH)-1:0]  step_idx
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int ENT_W = 2 + SW_W + CNT_W;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW_W-1:0]   sw_q, sw_d;
  logic              run_q, run_d;
  logic              cont_q, cont_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              adv;

  logic [ENT_W-1:0]  rd_data;
  op_e               ent_op;
  logic [SW_W-1:0]   ent_sw;
  logic [CNT_W-1:0]  ent_dly;

`ifndef STIM_SEQ_HANDSHAKE_EN
  logic unused_ready;
  assign unused_ready = ready;
`endif

  // The script is frozen while it runs.
  stim_script_ram #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (wr_en & ~busy_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  assign ent_op  = op_e'(rd_data[ENT_W-1 -: 2]);
  assign ent_sw  = rd_data[CNT_W +: SW_W];
  assign ent_dly = rd_data[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sw_d    = sw_q;
    adv     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_FETCH;
            idx_d   = '0;
          end
        end
        ST_FETCH: begin
          sw_d    = ent_sw;
          op_d    = ent_op;
          cnt_d   = ent_dly;
          state_d = (ent_op == OP_END) ? ST_DONE : ST_DELAY;
        end
        ST_DELAY: begin
          // Delay d gives d+1 DELAY cycles.
          if (cnt_q == '0) begin
            if (op_q == OP_RUN || op_q == OP_CONT) begin
              state_d = ST_PULSE;
              cnt_d   = CNT_W'(PULSE_W - 1);
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
`ifdef STIM_SEQ_HANDSHAKE_EN
            if (op_q == OP_CONT) state_d = ST_WAIT_RDY;
            else                 adv     = 1'b1;
`else
            adv = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`ifdef STIM_SEQ_HANDSHAKE_EN
        ST_WAIT_RDY: begin
          if (ready) adv = 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
      // Last entry finishes the script instead of wrapping.
      if (adv) begin
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
    end
  end

  // Flag outputs follow the next state so they are registered yet aligned.
  always_comb begin
    run_d  = (state_d == ST_PULSE) && (op_d == OP_RUN);
    cont_d = (state_d == ST_PULSE) && (op_d == OP_CONT);
    done_d = (state_d == ST_DONE);
`ifdef STIM_SEQ_HANDSHAKE_EN
    busy_d = state_d inside {ST_FETCH, ST_DELAY, ST_PULSE, ST_WAIT_RDY};
`else
    busy_d = state_d inside {ST_FETCH, ST_DELAY, ST_PULSE};
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      idx_q   <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      run_q   <= 1'b0;
      cont_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      run_q   <= run_d;
      cont_q  <= cont_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SW       = sw_q;
  assign Run      = run_q;
  assign Continue = cont_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_slc3_stim_seq.sv
// Self-checking bench for slc3_stim_seq: directed scenarios plus random scripts
// checked cycle by cycle against a timeline model built from the script.
module tb_slc3_stim_seq;
  import slc3_stim_pkg::*;

  localparam int DEPTH   = 32;
  localparam int PULSE_W = 4;
  localparam int EW      = 34;
`ifdef STIM_SEQ_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic          Clk, Reset, wr_en, start, abort, ready;
  logic [4:0]    wr_addr;
  logic [EW-1:0] wr_data;
  logic [15:0]   SW;
  logic          Run, Continue, busy, done;
  logic [4:0]    step_idx;

  slc3_stim_seq #(
    .SW_W(16), .DEPTH(DEPTH), .CNT_W(16), .PULSE_W(PULSE_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort), .ready(ready),
    .SW(SW), .Run(Run), .Continue(Continue), .busy(busy), .done(done),
    .step_idx(step_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errs = 0;
  int checks = 0;

  entry_t      mem_m [DEPTH];
  logic [15:0] model_sw;

  typedef struct {
    logic [15:0] sw;
    logic        run, cont, busy, done;
    logic [4:0]  idx;
  } exp_t;
  exp_t q[$];

  logic [15:0] obs_sw   [64];
  logic        obs_run  [64];
  logic        obs_cont [64];
  logic        obs_done [64];
  logic [4:0]  obs_idx  [64];

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_entry(input int a, input op_e op,
                             input logic [15:0] sw, input logic [15:0] d);
    entry_t e;
    e.op = op; e.sw = sw; e.delay = d;
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = e;
    cyc();
    wr_en = 1'b0;
    mem_m[a] = e;
  endtask

  function automatic void push(input logic [15:0] sw, input logic r,
      input logic c, input logic b, input logic dn, input int idx);
    exp_t x;
    x.sw = sw; x.run = r; x.cont = c; x.busy = b; x.done = dn;
    x.idx = 5'(idx);
    q.push_back(x);
  endfunction

  // Timeline: fetch 1 cycle, delay d+1 cycles, pulse PULSE_W cycles,
  // plus one ready-sampled cycle after CONT when the handshake is built in.
  function automatic void build();
    logic [15:0] sw;
    int last;
    q.delete();
    sw = model_sw;
    last = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push(sw, 0, 0, 1, 0, i);
      sw = mem_m[i].sw;
      last = i;
      if (mem_m[i].op == OP_END) break;
      for (int k = 0; k <= int'(mem_m[i].delay); k++) push(sw, 0, 0, 1, 0, i);
      if (mem_m[i].op == OP_RUN || mem_m[i].op == OP_CONT)
        for (int k = 0; k < PULSE_W; k++)
          push(sw, mem_m[i].op == OP_RUN, mem_m[i].op == OP_CONT, 1, 0, i);
      if (HS && mem_m[i].op == OP_CONT) push(sw, 0, 0, 1, 0, i);
    end
    push(sw, 0, 0, 0, 1, last);
    push(sw, 0, 0, 0, 1, last);
    model_sw = sw;
  endfunction

  task automatic run_script(input bit noise);
    logic [24:0] got, want;
    build();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      got  = {SW, Run, Continue, busy, done, step_idx};
      want = {q[k].sw, q[k].run, q[k].cont, q[k].busy, q[k].done, q[k].idx};
      checks++;
      if (got !== want) begin
        errs++;
        $display("FAIL trace[%0d] got sw=%h run=%b cont=%b busy=%b done=%b idx=%0d want sw=%h run=%b cont=%b busy=%b done=%b idx=%0d",
          k, SW, Run, Continue, busy, done, step_idx,
          q[k].sw, q[k].run, q[k].cont, q[k].busy, q[k].done, q[k].idx);
      end
      if (noise && q[k].busy) begin
        start   = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = 5'($urandom);
        wr_data = EW'({$urandom, $urandom});
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (k != q.size() - 1) cyc();
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic observe(input int n);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      obs_sw[c] = SW; obs_run[c] = Run; obs_cont[c] = Continue;
      obs_done[c] = done; obs_idx[c] = step_idx;
      cyc();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    model_sw = 16'h0;
    checks++;
    if ({SW, Run, Continue, busy, done, step_idx} !== 25'h0) begin
      errs++;
      $display("FAIL reset got sw=%h run=%b cont=%b busy=%b done=%b idx=%0d want all 0",
        SW, Run, Continue, busy, done, step_idx);
    end
  endtask

  task automatic test_cont_example();
    int first_done;
    write_entry(0, OP_CONT, 16'h0014, 16'd5);
    write_entry(1, OP_CONT, 16'h000F, 16'd5);
    write_entry(2, OP_END,  16'h0000, 16'd0);
    observe(40);
    checks++;
    if (obs_sw[2] !== 16'h0014) begin
      errs++;
      $display("FAIL ex_sw_c2 got %h want 0014", obs_sw[2]);
    end
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (obs_cont[c] !== (c >= 8 && c <= 11)) begin
        errs++;
        $display("FAIL ex_cont_c%0d got %b want %b", c, obs_cont[c], (c >= 8 && c <= 11));
      end
    end
    first_done = 0;
    for (int c = 40; c >= 1; c--) if (obs_done[c] === 1'b1) first_done = c;
    checks++;
    if (first_done != (HS ? 26 : 24) || obs_idx[40] !== 5'd2) begin
      errs++;
      $display("FAIL ex_done got cycle=%0d idx=%0d want cycle=%0d idx=2",
        first_done, obs_idx[40], HS ? 26 : 24);
    end
    model_sw = 16'h0000;
  endtask

  task automatic test_run_d0();
    write_entry(0, OP_RUN, 16'h0021, 16'd0);
    write_entry(1, OP_END, 16'h0021, 16'd0);
    observe(12);
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (obs_run[c] !== (c >= 3 && c <= 6) || obs_cont[c] !== 1'b0) begin
        errs++;
        $display("FAIL run_d0_c%0d got run=%b cont=%b want run=%b cont=0",
          c, obs_run[c], obs_cont[c], (c >= 3 && c <= 6));
      end
    end
    model_sw = 16'h0021;
  endtask

  task automatic test_abort();
    write_entry(0, OP_RUN, 16'hBEEF, 16'd0);
    write_entry(1, OP_END, 16'hBEEF, 16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    checks++;
    if (Run !== 1'b1) begin
      errs++;
      $display("FAIL abort_pre got run=%b want 1", Run);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if ({Run, Continue, busy, done, SW} !== {4'b0000, 16'hBEEF}) begin
      errs++;
      $display("FAIL abort_pulse got run=%b cont=%b busy=%b done=%b sw=%h want 0 0 0 0 beef",
        Run, Continue, busy, done, SW);
    end
    cyc();
    checks++;
    if ({Run, busy, done} !== 3'b000) begin
      errs++;
      $display("FAIL abort_idle got run=%b busy=%b done=%b want 0 0 0", Run, busy, done);
    end
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    cyc();
    checks++;
    if ({busy, done, Run} !== 3'b000) begin
      errs++;
      $display("FAIL start_abort got busy=%b done=%b run=%b want 0 0 0", busy, done, Run);
    end
    model_sw = 16'hBEEF;
    run_script(1'b0);
  endtask

  task automatic test_write_busy();
    entry_t e;
    write_entry(0, OP_NOP, 16'hAAAA, 16'd8);
    write_entry(1, OP_END, 16'h5555, 16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    e.op = OP_RUN; e.sw = 16'h1234; e.delay = 16'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = e;
    cyc();
    wr_en = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    checks++;
    if (done !== 1'b1 || SW !== 16'h5555) begin
      errs++;
      $display("FAIL wr_busy_done got done=%b sw=%h want 1 5555", done, SW);
    end
    model_sw = 16'h5555;
    run_script(1'b0);
  endtask

  task automatic test_reset_mid_delay();
    write_entry(0, OP_NOP, 16'h1111, 16'd20);
    write_entry(1, OP_END, 16'h2222, 16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    checks++;
    if ({SW, Run, Continue, busy, done, step_idx} !== 25'h0) begin
      errs++;
      $display("FAIL reset_delay got sw=%h run=%b cont=%b busy=%b done=%b idx=%0d want all 0",
        SW, Run, Continue, busy, done, step_idx);
    end
    model_sw = 16'h0;
    run_script(1'b0);
  endtask

  task automatic test_no_end();
    for (int i = 0; i < DEPTH; i++) write_entry(i, OP_NOP, 16'(i * 3 + 1), 16'd1);
    run_script(1'b0);
    checks++;
    if (step_idx !== 5'd31 || done !== 1'b1) begin
      errs++;
      $display("FAIL no_end got idx=%0d done=%b want 31 1", step_idx, done);
    end
  endtask

  task automatic test_random();
    int endpos;
    op_e op;
    for (int it = 0; it < 4; it++) begin
      endpos = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 2))
          0:       op = OP_NOP;
          1:       op = OP_RUN;
          default: op = OP_CONT;
        endcase
        if (i == endpos) op = OP_END;
        write_entry(i, op, 16'($urandom), 16'($urandom_range(0, 6)));
      end
      run_script(1'b1);
    end
  endtask

  task automatic test_handshake();
`ifdef STIM_SEQ_HANDSHAKE_EN
    write_entry(0, OP_CONT, 16'h0003, 16'd0);
    write_entry(1, OP_END,  16'h0077, 16'd0);
    ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({busy, Continue, step_idx} !== {2'b10, 5'd0}) begin
        errs++;
        $display("FAIL hs_wait%0d got busy=%b cont=%b idx=%0d want 1 0 0",
          i, busy, Continue, step_idx);
      end
      cyc();
    end
    ready = 1'b1;
    cyc();
    checks++;
    if (step_idx !== 5'd1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL hs_adv got idx=%0d busy=%b want 1 1", step_idx, busy);
    end
    cyc(); cyc();
    model_sw = 16'h0077;
`endif
  endtask

  initial begin
    Reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; abort = 1'b0; ready = 1'b1;
    model_sw = 16'h0;
    cyc();
    test_reset();
    test_cont_example();
    test_run_d0();
    test_abort();
    test_write_busy();
    test_reset_mid_delay();
    test_no_end();
    test_random();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
